vector_alu_wb_buffer: RTL
=========================

Name: vector_alu_wb_buffer

Overview:
- Downstream result stage for the vector FP ALU.
- Tracks every operation issued into the ALU with a tag, and captures the ALU result vector exactly LAT cycles after issue.
- Queues results in a small FIFO and presents them on a valid/ready output toward writeback.
- The ALU pipeline cannot stall, so this block also issues credits upstream; a result never arrives to a full buffer.

Parameters:
- ELE_NUM, 8, number of fp32 lanes; data width is 32*ELE_NUM.
- LAT, 3, fixed ALU latency in clock edges from issue acceptance to valid alu_d; must be >=1.
- DEPTH, 4, result FIFO entries and total credits; must be >=1.
- TAG_W, 4, width of the op tag carried alongside the data.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- issue_valid  in  1  upstream presents an op to the ALU this cycle.
- issue_ready  out  1  a credit is available; the op is accepted when valid&&ready.
- issue_tag  in  TAG_W  tag of the issued op.
- issue_ctrl  in  2  ALU mode: 00 add, 01 mul, 10 mul_add, 11 illegal.
- alu_d  in  32*ELE_NUM  ALU result vector.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  downstream consumes the head when valid&&ready.
- out_data  out  32*ELE_NUM  head result.
- out_tag  out  TAG_W  head tag.
- out_err  out  1  head op used an illegal ctrl.
- occupancy  out  $clog2(DEPTH+1)  entries currently held in the FIFO.

Behaviour:
- Reset (async, immediate): all outputs, pointers and delay line are cleared; credits=DEPTH.
  - After reset: issue_ready=1, out_valid=0, out_data=0, out_tag=0, out_err=0, occupancy=0.
- Credit counter:
  - Decrements on an issue accept and increments on a pop; a simultaneous accept and pop leaves it unchanged.
  - issue_ready = (credits != 0), decoded from the register only, so a pop does not raise ready in the same cycle.
  - Invariant: credits + in-flight + occupancy == DEPTH.
- Delay line:
  - LAT stages of {vld, tag, err}; stage 0 is loaded at the accept edge with err = (issue_ctrl == 2'b11).
  - The line shifts every cycle and never stalls.
  - When stage LAT-1 vld=1, alu_d is written into the FIFO at that edge together with the stage's tag and err.
  - Net effect: an op accepted at edge E0 has its alu_d sampled at edge E0+LAT, and out_valid can rise after that edge.
- FIFO:
  - Circular buffer with rd/wr pointers that wrap modulo DEPTH.
  - out_* are driven combinationally from mem[rd_ptr]; out_valid = (occupancy != 0).
  - out_data, out_tag and out_err hold their value while out_valid && !out_ready.
- Simultaneous events:
  - A write and a pop in the same cycle leave occupancy unchanged. This includes occupancy==0, where the write lands and out_valid is 1 next cycle; there is no bypass.
  - A write when occupancy==DEPTH cannot occur; it is a simulation assertion failure.
  - A pop when occupancy==0 is ignored.
- Illegal ctrl: the data is still captured (the ALU drives 0) and out_err=1. No other side effect.
- Reset mid-operation: in-flight ops and FIFO contents are discarded and credits are restored to DEPTH. Upstream must re-issue.

Decomposition:
- Shared package vector_alu_pkg holds:
  - ALU op codes OP_ADD=2'b00, OP_MUL=2'b01, OP_MULADD=2'b10, OP_ILLEGAL=2'b11.
  - Default VALU_LAT=3 and default lane count 8.
- One sub-module, vector_wb_fifo: parameterised synchronous FIFO (width, depth) with count output and async reset.
- The top level contains the credit counter and delay line.

Test Plan:
- Single op: tag=5, ctrl=00 issued at edge 0, alu_d=lane i value 0x3F800000+i at edge 3 → out_valid after edge 3, out_tag=5, out_err=0, data matches; pop → occupancy 0, credits=4.
- Back-pressure: out_ready=0, issue 6 back-to-back ops → exactly 4 accepted (issue_ready low from edge 4). After 3 more edges occupancy=4; then out_ready=1 → tags pop in order 0..3 and issue_ready returns.
- Simultaneous: occupancy=2 with a write and a pop on the same edge → occupancy stays 2 and credits are unchanged.
- Illegal ctrl=11, tag=9 → entry appears LAT edges later with out_err=1 and out_data=0.
- Wrap: 10 ops streamed with out_ready=1 and DEPTH=4 → tags 0..9 emerge in order, no loss, pointers wrap twice.
- Reset asserted asynchronously with 2 ops in flight and 1 in the FIFO → immediately out_valid=0, occupancy=0, issue_ready=1. No stale entry appears after reset is released.

Source files
------------

// File: rtl/vector_alu_pkg.sv
// Shared definitions for the vector FP ALU and its writeback result stage.
package vector_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD     = 2'b00,
    OP_MUL     = 2'b01,
    OP_MULADD  = 2'b10,
    OP_ILLEGAL = 2'b11
  } alu_op_e;

  localparam int VALU_LAT     = 3;
  localparam int VALU_ELE_NUM = 8;

  function automatic logic is_illegal_op(input logic [1:0] ctrl);
    return alu_op_e'(ctrl) == OP_ILLEGAL;
  endfunction

endpackage

// File: rtl/vector_wb_fifo.sv
// Parameterised circular-buffer FIFO with occupancy count; the head is read
// combinationally, and a read from an empty FIFO is ignored.
module vector_wb_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_rd;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_rd   = rd_en && (count != '0);
  assign valid   = (count != '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= bump(wr_ptr);
      end
      if (do_rd) rd_ptr <= bump(rd_ptr);
      case ({wr_en, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Upstream credit flow control makes a write into a full buffer impossible.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(wr_en && (count == CNT_W'(DEPTH))));
  end

endmodule

// File: rtl/vector_alu_wb_buffer.sv
// Result stage for the vector FP ALU: tags each issued op through a fixed-latency
// delay line, captures alu_d into a FIFO and grants issue credits upstream.
module vector_alu_wb_buffer
  import vector_alu_pkg::*;
#(
  parameter int ELE_NUM = VALU_ELE_NUM,
  parameter int LAT     = VALU_LAT,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  localparam int DW     = 32 * ELE_NUM,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [TAG_W-1:0] issue_tag,
  input  logic [1:0]       issue_ctrl,
  input  logic [DW-1:0]    alu_d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic [CNT_W-1:0] occupancy
);

  localparam int FW = DW + TAG_W + 1;

  logic [CNT_W-1:0] credits;
  logic             accept;
  logic             pop;
  logic [LAT-1:0]   dl_vld;
  logic [LAT-1:0]   dl_err;
  logic [TAG_W-1:0] dl_tag [LAT];
  logic [FW-1:0]    head;

  // Ready comes from the credit register alone, so a pop frees a credit one cycle later.
  assign issue_ready = (credits != '0);
  assign accept      = issue_valid && issue_ready;
  assign pop         = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits <= CNT_W'(DEPTH);
    end else begin
      case ({accept, pop})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  // The ALU cannot stall, so the tag/err line shifts unconditionally every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dl_vld <= '0;
      dl_err <= '0;
      for (int i = 0; i < LAT; i++) dl_tag[i] <= '0;
    end else begin
      dl_vld[0] <= accept;
      dl_err[0] <= is_illegal_op(issue_ctrl);
      dl_tag[0] <= issue_tag;
      for (int i = 1; i < LAT; i++) begin
        dl_vld[i] <= dl_vld[i-1];
        dl_err[i] <= dl_err[i-1];
        dl_tag[i] <= dl_tag[i-1];
      end
    end
  end

  vector_wb_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (dl_vld[LAT-1]),
    .wr_data ({dl_err[LAT-1], dl_tag[LAT-1], alu_d}),
    .rd_en   (out_ready),
    .rd_data (head),
    .valid   (out_valid),
    .count   (occupancy)
  );

  assign {out_err, out_tag, out_data} = head;

endmodule
